// File: rtl/acc_seq.sv
// Sequencer for a DSP-style accumulate run: drives CEP/RSTP/ACC_SEL of an
// external P register and counts accepted beats.
module acc_seq #(
  parameter int PREG = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [7:0] LEN,
  input  logic       IN_VALID,
  input  logic       ABORT,
  output logic       CEP,
  output logic       RSTP,
  output logic       ACC_SEL,
  output logic       BUSY,
  output logic       OUT_VALID,
  output logic [7:0] BEAT_CNT,
  output logic       ERR
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_len, r_cnt;
  logic       r_err;
  logic       w_start_ok, w_rej, w_last, w_beat;

  assign w_start_ok = START && (LEN != 8'd0);
  assign w_rej      = START && ((r_state != S_IDLE) || (LEN == 8'd0));
  assign w_last     = IN_VALID && ((r_cnt + 8'd1) == r_len);
  assign w_beat     = (r_state == S_ACCUM) && IN_VALID && !ABORT;

  always_comb begin
    w_next    = r_state;
    CEP       = 1'b0;
    RSTP      = 1'b0;
    OUT_VALID = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_CLEAR;
      S_CLEAR: begin
        CEP    = 1'b1;
        RSTP   = 1'b1;
        w_next = S_ACCUM;
      end
      S_ACCUM: begin
        CEP = IN_VALID;
        if (w_last) begin
          // Without the P register the sum is already at the output on the last beat.
          if (PREG == 0) begin
            OUT_VALID = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_next    = S_DONE;
          end
        end
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides everything, including a coincident last beat.
    if (ABORT && (r_state != S_IDLE)) begin
      CEP       = 1'b1;
      RSTP      = 1'b1;
      OUT_VALID = 1'b0;
      w_next    = S_IDLE;
    end
  end

  assign BUSY     = (r_state != S_IDLE);
  assign ACC_SEL  = BUSY && (r_cnt != 8'd0);
  assign BEAT_CNT = r_cnt;
  assign ERR      = r_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_rej;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_len <= LEN;
        r_cnt <= 8'd0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule
